// File: rtl/ice_pkg.sv
// ============================================================================
// ice_pkg : types and defaults shared by the ICE board sequencing logic
// Rev 1.0
// ============================================================================
`default_nettype none

package ice_pkg;

   localparam int PSEQ_DELAY_W = 16;

   typedef enum logic [1:0] {
      PSEQ_OFF       = 2'd0,
      PSEQ_RAMP_UP   = 2'd1,
      PSEQ_ON        = 2'd2,
      PSEQ_RAMP_DOWN = 2'd3
   } pseq_state_t;

endpackage

`default_nettype wire

// File: rtl/pseq_step_timer.sv
// ============================================================================
// pseq_step_timer : loadable settle down-counter that holds at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module pseq_step_timer
   import ice_pkg::*;
#(
   parameter int DELAY_W = PSEQ_DELAY_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DELAY_W-1:0] load_val,
   output logic               zero
);

   logic [DELAY_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - DELAY_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/m3_power_seq.sv
// ============================================================================
// m3_power_seq : ordered power-rail sequencer with abort and emergency-off
// Rev 1.0
// ============================================================================
`default_nettype none

module m3_power_seq
   import ice_pkg::*;
#(
   parameter int                   NUM_RAILS  = 3,
   parameter int                   DELAY_W    = PSEQ_DELAY_W,
   parameter logic [NUM_RAILS-1:0] ACTIVE_LOW = {NUM_RAILS{1'b0}}
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 up_req,
   input  logic                 down_req,
   input  logic [DELAY_W-1:0]   delay,
   input  logic                 fault,
   output logic [NUM_RAILS-1:0] rail_sw,
   output logic [1:0]           state,
   output logic                 busy,
   output logic                 done,
   output logic                 fault_flag
);

   localparam int                 IDX_W    = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_RAILS - 1);

   pseq_state_t            st;
   logic [IDX_W-1:0]       idx;
   logic [DELAY_W-1:0]     d_lat;
   logic [NUM_RAILS-1:0]   rail_on;
   logic                   t_load;
   logic [DELAY_W-1:0]     t_load_val;
   logic                   t_zero;
   logic [IDX_W-1:0]       idx_inc;
   logic [IDX_W-1:0]       idx_dec;

   assign idx_inc = idx + IDX_W'(1);
   assign idx_dec = idx - IDX_W'(1);

   // Timer reload mirrors every FSM event that restarts a settle period;
   // a fault clears it so no stale count survives into the next ramp.
   always_comb begin
      t_load     = 1'b0;
      t_load_val = d_lat;
      if (fault) begin
         t_load     = 1'b1;
         t_load_val = '0;
      end else begin
         case (st)
            PSEQ_OFF: begin
               if (up_req) begin
                  t_load     = 1'b1;
                  t_load_val = delay;
               end
            end
            PSEQ_RAMP_UP: begin
               if (down_req) begin
                  t_load     = 1'b1;
                  t_load_val = delay;
               end else if (t_zero && (idx != LAST_IDX)) begin
                  t_load = 1'b1;
               end
            end
            PSEQ_ON: begin
               if (down_req) begin
                  t_load     = 1'b1;
                  t_load_val = delay;
               end
            end
            PSEQ_RAMP_DOWN: begin
               if (t_zero && (idx != '0)) begin
                  t_load = 1'b1;
               end
            end
            default: begin
               t_load = 1'b0;
            end
         endcase
      end
   end

   pseq_step_timer #(
      .DELAY_W (DELAY_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (t_load),
      .load_val (t_load_val),
      .zero     (t_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= PSEQ_OFF;
         idx        <= '0;
         d_lat      <= '0;
         rail_on    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault_flag <= 1'b0;
      end else begin
         done <= 1'b0;
         if (fault) begin
            st         <= PSEQ_OFF;
            idx        <= '0;
            rail_on    <= '0;
            busy       <= 1'b0;
            fault_flag <= 1'b1;
         end else begin
            case (st)
               PSEQ_OFF: begin
                  if (up_req) begin
                     d_lat      <= delay;
                     fault_flag <= 1'b0;
                     rail_on[0] <= 1'b1;
                     idx        <= '0;
                     st         <= PSEQ_RAMP_UP;
                     busy       <= 1'b1;
                  end
               end
               PSEQ_RAMP_UP: begin
                  if (down_req) begin
                     // abort: the rail just switched on is the first to drop
                     d_lat        <= delay;
                     rail_on[idx] <= 1'b0;
                     st           <= PSEQ_RAMP_DOWN;
                  end else if (t_zero) begin
                     if (idx != LAST_IDX) begin
                        idx              <= idx_inc;
                        rail_on[idx_inc] <= 1'b1;
                     end else begin
                        st   <= PSEQ_ON;
                        done <= 1'b1;
                        busy <= 1'b0;
                     end
                  end
               end
               PSEQ_ON: begin
                  if (down_req) begin
                     d_lat                <= delay;
                     rail_on[NUM_RAILS-1] <= 1'b0;
                     idx                  <= LAST_IDX;
                     st                   <= PSEQ_RAMP_DOWN;
                     busy                 <= 1'b1;
                  end
               end
               PSEQ_RAMP_DOWN: begin
                  if (t_zero) begin
                     if (idx != '0) begin
                        idx              <= idx_dec;
                        rail_on[idx_dec] <= 1'b0;
                     end else begin
                        st   <= PSEQ_OFF;
                        done <= 1'b1;
                        busy <= 1'b0;
                     end
                  end
               end
               default: begin
                  st <= PSEQ_OFF;
               end
            endcase
         end
      end
   end

   // Board wiring: bit 0 -> M3_VBATT_SW, bit 1 -> M3_1P2_SW, bit 2 -> M3_0P6_SW.
   assign rail_sw = rail_on ^ ACTIVE_LOW;
   assign state   = st;

endmodule

`default_nettype wire

// File: tb/tb_m3_power_seq.sv
// ============================================================================
// tb_m3_power_seq : vector table, corner sequences and random run vs timing model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_m3_power_seq;

   localparam int         N    = 3;
   localparam logic [2:0] POL  = 3'b101;
   localparam int         S_OFF = 0, S_UP = 1, S_ON = 2, S_DN = 3;

   logic        clk = 1'b0;
   logic        reset, up_req, down_req, fault;
   logic [15:0] delay;
   logic [2:0]  rail_sw;
   logic [1:0]  state;
   logic        busy, done, fault_flag;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model: ramps are described by their start cycle and arithmetic
   int m_st = S_OFF, m_t0 = 0, m_d = 0, m_top = 0;
   bit m_ff = 1'b0, m_done = 1'b0;

   always #5 clk = ~clk;

   m3_power_seq #(
      .NUM_RAILS  (N),
      .DELAY_W    (16),
      .ACTIVE_LOW (POL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .up_req     (up_req),
      .down_req   (down_req),
      .delay      (delay),
      .fault      (fault),
      .rail_sw    (rail_sw),
      .state      (state),
      .busy       (busy),
      .done       (done),
      .fault_flag (fault_flag)
   );

   typedef struct {
      bit       up, dn, f;
      int       d;
      int       st;
      bit [2:0] rails;
      bit       dn_pulse, bsy, ff;
   } vec_t;

   function automatic int up_count(input int e, input int d);
      int c;
      if (e < 0) return 0;
      c = e / (d + 1) + 1;
      return (c > N) ? N : c;
   endfunction

   function automatic int down_count(input int e, input int d, input int top);
      int c;
      c = top - e / (d + 1);
      return (c < 0) ? 0 : c;
   endfunction

   function automatic logic [2:0] model_rails();
      int c;
      case (m_st)
         S_UP:    c = up_count(cyc - m_t0 - 1, m_d);
         S_ON:    c = N;
         S_DN:    c = down_count(cyc - m_t0 - 1, m_d, m_top);
         default: c = 0;
      endcase
      return 3'((1 << c) - 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock: drive, advance model across the edge, compare against model
   task automatic step(input bit r, input bit u, input bit dn, input bit f, input int d);
      reset = r; up_req = u; down_req = dn; fault = f; delay = 16'(d);
      @(posedge clk);
      m_done = 1'b0;
      if (r) begin
         m_st = S_OFF; m_ff = 1'b0;
      end else if (f) begin
         m_st = S_OFF; m_ff = 1'b1;
      end else begin
         case (m_st)
            S_OFF: if (u) begin m_st = S_UP; m_t0 = cyc; m_d = d; m_ff = 1'b0; end
            S_UP: begin
               if (dn) begin
                  m_top = up_count(cyc - m_t0 - 1, m_d) - 1;
                  m_st = S_DN; m_t0 = cyc; m_d = d;
               end else if (cyc - m_t0 == N * (m_d + 1)) begin
                  m_st = S_ON; m_done = 1'b1;
               end
            end
            S_ON: if (dn) begin m_st = S_DN; m_t0 = cyc; m_d = d; m_top = N - 1; end
            default: if (cyc - m_t0 == (m_top + 1) * (m_d + 1)) begin
               m_st = S_OFF; m_done = 1'b1;
            end
         endcase
      end
      cyc++;
      #1;
      check("rail_sw", 32'(rail_sw), 32'(model_rails() ^ POL));
      check("state", 32'(state), 32'(m_st));
      check("busy", 32'(busy), 32'((m_st == S_UP) || (m_st == S_DN)));
      check("done", 32'(done), 32'(m_done));
      check("fault_flag", 32'(fault_flag), 32'(m_ff));
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         step(0, 0, 0, 0, 9);
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   vec_t vt[$];

   initial begin
      int c0, at;
      bit r, u, dn, f;

      // zero-delay table: expected values written directly from the timing rules
      vt.push_back('{1,0,0,0, S_UP, 3'b001, 0,1,0});
      vt.push_back('{0,0,0,0, S_UP, 3'b011, 0,1,0});
      vt.push_back('{0,0,0,0, S_UP, 3'b111, 0,1,0});
      vt.push_back('{0,0,0,0, S_ON, 3'b111, 1,0,0});
      vt.push_back('{0,0,0,0, S_ON, 3'b111, 0,0,0});
      vt.push_back('{1,0,0,0, S_ON, 3'b111, 0,0,0});
      vt.push_back('{1,1,0,0, S_DN, 3'b011, 0,1,0});
      vt.push_back('{0,0,0,0, S_DN, 3'b001, 0,1,0});
      vt.push_back('{0,0,0,0, S_DN, 3'b000, 0,1,0});
      vt.push_back('{0,0,0,0, S_OFF,3'b000, 1,0,0});
      vt.push_back('{0,1,0,0, S_OFF,3'b000, 0,0,0});
      vt.push_back('{1,1,0,0, S_UP, 3'b001, 0,1,0});
      vt.push_back('{0,0,1,0, S_OFF,3'b000, 0,0,1});
      vt.push_back('{1,0,1,0, S_OFF,3'b000, 0,0,1});
      vt.push_back('{1,0,0,0, S_UP, 3'b001, 0,1,0});
      vt.push_back('{0,0,1,0, S_OFF,3'b000, 0,0,1});

      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      check("reset rail_sw", 32'(rail_sw), 32'(3'b101));
      check("reset state", 32'(state), 32'(S_OFF));

      foreach (vt[i]) begin
         step(0, vt[i].up, vt[i].dn, vt[i].f, vt[i].d);
         check("vec rails", 32'(rail_sw), 32'(vt[i].rails ^ POL));
         check("vec state", 32'(state), 32'(vt[i].st));
         check("vec done", 32'(done), 32'(vt[i].dn_pulse));
         check("vec busy", 32'(busy), 32'(vt[i].bsy));
         check("vec fault_flag", 32'(fault_flag), 32'(vt[i].ff));
      end

      // basic up/down with D=4; delay input changes afterwards must not matter
      step(1, 0, 0, 0, 0);
      c0 = cyc;
      step(0, 1, 0, 0, 4);
      wait_done(40, at);
      check("up done latency", 32'(at - c0), 32'(16));
      check("full on rail_sw", 32'(rail_sw), 32'(3'b010));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
      c0 = cyc;
      step(0, 0, 1, 0, 4);
      wait_done(40, at);
      check("down done latency", 32'(at - c0), 32'(16));

      // abort with rails 0 and 1 on
      c0 = cyc;
      step(0, 1, 0, 0, 4);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 2);
      check("pre-abort rails", 32'(rail_sw), 32'(3'b011 ^ POL));
      c0 = cyc;
      step(0, 0, 1, 0, 4);
      check("abort rail1 off", 32'(rail_sw), 32'(3'b001 ^ POL));
      wait_done(40, at);
      check("abort done latency", 32'(at - c0), 32'(11));
      check("abort final state", 32'(state), 32'(S_OFF));

      // reset mid-ramp opens every rail on that edge
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      check("mid-ramp reset", 32'(rail_sw), 32'(3'b101));

      // random run against the model
      for (int i = 0; i < 5000; i++) begin
         r  = ($urandom_range(0, 999) == 0);
         u  = ($urandom_range(0, 11) == 0);
         dn = ($urandom_range(0, 19) == 0);
         f  = ($urandom_range(0, 149) == 0);
         step(r, u, dn, f, int'($urandom_range(0, 5)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
